// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@72 Hz raster constants and the coordinate type.
// Ports: none (package only).
package vga_timing_pkg;
   localparam int COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;
   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 24;
   localparam int H_SYNC   = 40;
   localparam int H_BP     = 128;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 9;
   localparam int V_SYNC   = 3;
   localparam int V_BP     = 28;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic SYNC_ACTIVE_LOW = 1'b0;
endpackage

// File: rtl/vga_timing_sync_delay.sv
// sync_delay: DEPTH-stage shift register with reset value RST_VAL; DEPTH=0 is a wire.
// Ports: px_clk clock, reset_n sync active-low reset, d input word, q d delayed DEPTH clocks.
module sync_delay #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             px_clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   if (DEPTH == 0) begin : g_wire
      assign q = d;
   end else begin : g_sr
      logic [WIDTH-1:0] sr [DEPTH];
      always_ff @(posedge px_clk) begin
         if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
         end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
         end
      end
      assign q = sr[DEPTH-1];
   end
endmodule

// File: rtl/vga_timing.sv
// vga_timing: free-running VGA raster counters with registered coordinate, blanking and sync decode.
// Ports: px_clk pixel clock, reset_n sync active-low reset, x_px/y_px pixel coordinate,
//        activevideo visible-area flag, hsync/vsync aligned syncs, hsync_d/vsync_d syncs delayed
//        SYNC_DELAY clocks, line_start/frame_start one-cycle strobes at x=0 / (0,0).
module vga_timing
   import vga_timing_pkg::coord_t;
   import vga_timing_pkg::COORD_W;
#(
   parameter int   H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
   parameter int   H_FP       = vga_timing_pkg::H_FP,
   parameter int   H_SYNC     = vga_timing_pkg::H_SYNC,
   parameter int   H_BP       = vga_timing_pkg::H_BP,
   parameter int   V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
   parameter int   V_FP       = vga_timing_pkg::V_FP,
   parameter int   V_SYNC     = vga_timing_pkg::V_SYNC,
   parameter int   V_BP       = vga_timing_pkg::V_BP,
   parameter logic HSYNC_POL  = vga_timing_pkg::SYNC_ACTIVE_LOW,
   parameter logic VSYNC_POL  = vga_timing_pkg::SYNC_ACTIVE_LOW,
   parameter int   SYNC_DELAY = 2
) (
   input  logic               px_clk,
   input  logic               reset_n,
   output logic [COORD_W-1:0] x_px,
   output logic [COORD_W-1:0] y_px,
   output logic               activevideo,
   output logic               hsync,
   output logic               vsync,
   output logic               hsync_d,
   output logic               vsync_d,
   output logic               line_start,
   output logic               frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   if (H_TOTAL > 2**COORD_W || V_TOTAL > 2**COORD_W) begin : g_width_check
      $error("vga_timing: raster totals exceed the coordinate width");
   end
   localparam coord_t H_ACT   = coord_t'(H_ACTIVE);
   localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
   localparam coord_t HS_BEG  = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HS_END  = coord_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t V_ACT   = coord_t'(V_ACTIVE);
   localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
   localparam coord_t VS_BEG  = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VS_END  = coord_t'(V_ACTIVE + V_FP + V_SYNC);
   coord_t h, v;
   logic   h_last;
   assign h_last = h == H_LAST;
   // Outputs are decoded from the pre-increment (h,v) so every output describes the same pixel.
   always_ff @(posedge px_clk) begin
      if (!reset_n) begin
         h           <= '0;
         v           <= '0;
         x_px        <= '0;
         y_px        <= '0;
         activevideo <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
      end else begin
         h           <= h_last ? '0 : h + coord_t'(1);
         v           <= h_last ? (v == V_LAST ? '0 : v + coord_t'(1)) : v;
         x_px        <= h;
         y_px        <= v;
         activevideo <= h < H_ACT && v < V_ACT;
         line_start  <= h == '0;
         frame_start <= h == '0 && v == '0;
         hsync       <= (h >= HS_BEG && h < HS_END) ? HSYNC_POL : ~HSYNC_POL;
         vsync       <= (v >= VS_BEG && v < VS_END) ? VSYNC_POL : ~VSYNC_POL;
      end
   end
   // Matches the renderer's colour pipeline so sync and colour leave together.
   sync_delay #(
      .WIDTH  (2),
      .DEPTH  (SYNC_DELAY),
      .RST_VAL({~HSYNC_POL, ~VSYNC_POL})
   ) u_sync_delay (
      .px_clk (px_clk),
      .reset_n(reset_n),
      .d      ({hsync, vsync}),
      .q      ({hsync_d, vsync_d})
   );
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of the default raster and of a shrunken raster with no sync delay.
module tb_vga_timing;
   logic px_clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_s_n = 1'b0;
   logic [9:0] x, y, xs, ys;
   logic av, hs, vs, hsd, vsd, ls, fs;
   logic avs, hss, vss, hsds, vsds, lss, fss;
   int errors = 0;
   int checks = 0;

   always #5 px_clk = ~px_clk;

   vga_timing u_dut (
      .px_clk(px_clk), .reset_n(rst_n), .x_px(x), .y_px(y), .activevideo(av),
      .hsync(hs), .vsync(vs), .hsync_d(hsd), .vsync_d(vsd),
      .line_start(ls), .frame_start(fs)
   );

   // 16x8 raster: hsync x 10..12, vsync y 5..6, visible 8x4.
   vga_timing #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_DELAY(0)
   ) u_small (
      .px_clk(px_clk), .reset_n(rst_s_n), .x_px(xs), .y_px(ys), .activevideo(avs),
      .hsync(hss), .vsync(vss), .hsync_d(hsds), .vsync_d(vsds),
      .line_start(lss), .frame_start(fss)
   );

   task automatic step();
      @(posedge px_clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      checks++;
      if ({x, y, av, hs, vs, hsd, vsd, ls, fs} !== {10'd0, 10'd0, 7'b0111100}) begin
         errors++;
         $display("FAIL reset_state: x=%0d y=%0d av=%b hs=%b vs=%b hsd=%b vsd=%b ls=%b fs=%b, want 0 0 0 1 1 1 1 0 0",
                  x, y, av, hs, vs, hsd, vsd, ls, fs);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if ({x, y, av, hs, vs, ls, fs} !== {10'd0, 10'd0, 5'b11111}) begin
         errors++;
         $display("FAIL first_pixel: x=%0d y=%0d av=%b hs=%b vs=%b ls=%b fs=%b, want 0 0 1 1 1 1 1",
                  x, y, av, hs, vs, ls, fs);
      end
   endtask

   task automatic test_horizontal();
      int seq_bad = 0, av_bad = 0, vs_bad = 0;
      int hs_cnt = 0, hs_first = -1, hs_last = -1;
      int hsd_cnt = 0, hsd_first = -1, hsd_last = -1;
      for (int i = 0; i < 832; i++) begin
         if (i > 0) step();
         if (x !== 10'(i) || y !== 10'd0) seq_bad++;
         if (av !== 1'(i < 640)) av_bad++;
         if (vs !== 1'b1) vs_bad++;
         if (hs === 1'b0) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = i;
            hs_last = i;
         end
         if (hsd === 1'b0) begin
            hsd_cnt++;
            if (hsd_first < 0) hsd_first = i;
            hsd_last = i;
         end
      end
      checks++;
      if (seq_bad != 0) begin errors++; $display("FAIL x_sequence: %0d bad samples, want 0", seq_bad); end
      checks++;
      if (av_bad != 0) begin errors++; $display("FAIL av_line: %0d bad samples, want 0", av_bad); end
      checks++;
      if (vs_bad != 0) begin errors++; $display("FAIL vs_line0: %0d asserted samples, want 0", vs_bad); end
      checks++;
      if (hs_cnt != 40 || hs_first != 664 || hs_last != 703) begin
         errors++;
         $display("FAIL hsync_window: cnt=%0d first=%0d last=%0d, want 40 664 703", hs_cnt, hs_first, hs_last);
      end
      checks++;
      if (hsd_cnt != 40 || hsd_first != 666 || hsd_last != 705) begin
         errors++;
         $display("FAIL hsync_d_window: cnt=%0d first=%0d last=%0d, want 40 666 705", hsd_cnt, hsd_first, hsd_last);
      end
      step();
      checks++;
      if ({x, y, ls, fs, av} !== {10'd0, 10'd1, 3'b101}) begin
         errors++;
         $display("FAIL line_wrap: x=%0d y=%0d ls=%b fs=%b av=%b, want 0 1 1 0 1", x, y, ls, fs, av);
      end
   endtask

   task automatic test_mid_reset();
      repeat (700) step();
      checks++;
      if ({x, y, hs, hsd, vs} !== {10'd700, 10'd1, 3'b001}) begin
         errors++;
         $display("FAIL pre_reset: x=%0d y=%0d hs=%b hsd=%b vs=%b, want 700 1 0 0 1", x, y, hs, hsd, vs);
      end
      rst_n = 1'b0;
      step();
      checks++;
      if ({x, y, av, hs, hsd, vsd, ls, fs} !== {10'd0, 10'd0, 6'b011100}) begin
         errors++;
         $display("FAIL mid_reset: x=%0d y=%0d av=%b hs=%b hsd=%b vsd=%b ls=%b fs=%b, want 0 0 0 1 1 1 0 0",
                  x, y, av, hs, hsd, vsd, ls, fs);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if ({x, y, fs, av, hs, hsd} !== {10'd0, 10'd0, 4'b1111}) begin
         errors++;
         $display("FAIL restart: x=%0d y=%0d fs=%b av=%b hs=%b hsd=%b, want 0 0 1 1 1 1", x, y, fs, av, hs, hsd);
      end
      repeat (665) step();
      checks++;
      if ({x, hs, hsd} !== {10'd665, 2'b01}) begin
         errors++;
         $display("FAIL restart_665: x=%0d hs=%b hsd=%b, want 665 0 1", x, hs, hsd);
      end
      step();
      checks++;
      if ({x, hsd} !== {10'd666, 1'b0}) begin
         errors++;
         $display("FAIL restart_666: x=%0d hsd=%b, want 666 0", x, hsd);
      end
   endtask

   task automatic test_small_frame();
      int fs_cnt = 0;
      logic [9:0] ex, ey;
      logic eav, ehs, evs;
      rst_s_n = 1'b0;
      repeat (2) step();
      rst_s_n = 1'b1;
      for (int i = 0; i < 256; i++) begin
         step();
         ex  = 10'(i % 16);
         ey  = 10'((i / 16) % 8);
         eav = ex < 8 && ey < 4;
         ehs = !(ex >= 10 && ex < 13);
         evs = !(ey >= 5 && ey < 7);
         if (fss === 1'b1) fs_cnt++;
         checks++;
         if ({xs, ys, avs, hss, vss, hsds, vsds, lss, fss} !==
             {ex, ey, eav, ehs, evs, ehs, evs, ex == 10'd0, ex == 10'd0 && ey == 10'd0}) begin
            errors++;
            $display("FAIL small_raster[%0d]: x=%0d y=%0d av=%b hs=%b vs=%b hsd=%b vsd=%b ls=%b fs=%b, want %0d %0d %b %b %b %b %b",
                     i, xs, ys, avs, hss, vss, hsds, vsds, lss, fss, ex, ey, eav, ehs, evs, ehs, evs);
         end
      end
      checks++;
      if (fs_cnt != 2) begin errors++; $display("FAIL small_frame_count: %0d, want 2", fs_cnt); end
   endtask

   task automatic test_small_mid_reset();
      repeat (92) step();
      checks++;
      if ({xs, ys, hss, vss} !== {10'd11, 10'd5, 2'b00}) begin
         errors++;
         $display("FAIL small_pre_reset: x=%0d y=%0d hs=%b vs=%b, want 11 5 0 0", xs, ys, hss, vss);
      end
      rst_s_n = 1'b0;
      step();
      checks++;
      if ({xs, ys, avs, hss, vss, hsds, vsds, fss} !== {10'd0, 10'd0, 6'b011110}) begin
         errors++;
         $display("FAIL small_mid_reset: x=%0d y=%0d av=%b hs=%b vs=%b hsd=%b vsd=%b fs=%b, want 0 0 0 1 1 1 1 0",
                  xs, ys, avs, hss, vss, hsds, vsds, fss);
      end
      rst_s_n = 1'b1;
      step();
      checks++;
      if ({xs, ys, fss, avs, vss} !== {10'd0, 10'd0, 3'b111}) begin
         errors++;
         $display("FAIL small_restart: x=%0d y=%0d fs=%b av=%b vs=%b, want 0 0 1 1 1", xs, ys, fss, avs, vss);
      end
   endtask

   initial begin
      test_reset();
      test_horizontal();
      test_mid_reset();
      test_small_frame();
      test_small_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Generates 640×480 @ 72 Hz VGA raster timing from the 31.5 MHz pixel clock.
- Feeds pixel coordinates and the active-video flag to the Nyancat renderer.
- Provides hsync/vsync copies delayed to match that renderer's 2-cycle colour pipeline, so sync and rrggbb leave the chip aligned.
- Also emits line_start and frame_start strobes for the frame-sequencing logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 40, hsync pulse width (clocks)
- H_BP, 128, horizontal back porch (clocks); H_TOTAL = 832
- V_ACTIVE, 480, visible lines per frame
- V_FP, 9, vertical front porch (lines)
- V_SYNC, 3, vsync pulse width (lines)
- V_BP, 28, vertical back porch (lines); V_TOTAL = 520
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- SYNC_DELAY, 2, extra clocks on hsync_d/vsync_d (0 = equal to hsync/vsync)

Ports:
- px_clk  input  1  pixel clock, 31.5 MHz
- reset_n  input  1  synchronous active-low reset
- x_px  output  10  horizontal counter, 0..H_TOTAL-1
- y_px  output  10  vertical counter, 0..V_TOTAL-1
- activevideo  output  1  high when x_px<H_ACTIVE and y_px<V_ACTIVE
- hsync  output  1  horizontal sync aligned with x_px/y_px
- vsync  output  1  vertical sync aligned with x_px/y_px
- hsync_d  output  1  hsync delayed SYNC_DELAY clocks
- vsync_d  output  1  vsync delayed SYNC_DELAY clocks
- line_start  output  1  one-cycle pulse while x_px==0
- frame_start  output  1  one-cycle pulse while x_px==0 and y_px==0

Behaviour:
- Reset: one clock, synchronous active-low; reset_n is sampled only on the px_clk rising edge. While reset_n=0, on each edge:
  - internal counters h=0, v=0;
  - x_px=0, y_px=0, activevideo=0, line_start=0, frame_start=0;
  - hsync=hsync_d=~HSYNC_POL and vsync=vsync_d=~VSYNC_POL (deasserted);
  - every stage of the delay line loads the deasserted level.
- Counting:
  - h increments every clock; it wraps H_TOTAL-1→0.
  - v increments only when h wraps; it wraps V_TOTAL-1→0 on the same edge that h wraps.
- Output registration: every output except the _d pair is registered and decoded from (h,v) on the same edge, so all outputs describe one pixel. The first edge with reset_n=1 presents (0,0): activevideo=1, line_start=1, frame_start=1; the counters move to (1,0).
- hsync: asserted when H_ACTIVE+H_FP ≤ x_px < H_ACTIVE+H_FP+H_SYNC, i.e. x 664..703 (40 clocks).
- vsync: asserted for whole lines V_ACTIVE+V_FP ≤ y_px < V_ACTIVE+V_FP+V_SYNC, i.e. y 489..491. Edges coincide with x_px=0.
- Width rules:
  - all compares are unsigned 10-bit;
  - the H_TOTAL and V_TOTAL derived sums must be ≤1024 (elaboration-time check);
  - x_px/y_px never exceed H_TOTAL-1 / V_TOTAL-1.
- Blanking: x_px/y_px keep counting through blanking; downstream gates output with activevideo.
- Delay line:
  - hsync_d/vsync_d equal hsync/vsync delayed exactly SYNC_DELAY edges, as a shift register.
  - With SYNC_DELAY=0 they are wired equal to hsync/vsync.
  - Intended alignment: rrggbb(n) pairs with hsync_d(n).
- Reset mid-frame: takes effect on the next edge. All outputs, including the delay line, return to reset values, and the raster restarts at (0,0) after release with no partial sync pulse.
- No other inputs: the block is free-running and has no handshake.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the 640×480@72 timing localparams (H_*/V_* defaults, H_TOTAL, V_TOTAL);
  - COORD_W=10;
  - SYNC_ACTIVE_LOW=0.
- The renderer and the top level reuse COORD_W and the active sizes from it.
- One sub-module, sync_delay: parameterised WIDTH=2, DEPTH=SYNC_DELAY shift register with reset value RST_VAL, handling the DEPTH=0 pass-through.

Test Plan:
- Reset then release: during reset x=0, y=0, activevideo=0, hsync=vsync=hsync_d=vsync_d=1. First post-release edge gives x=0, y=0, activevideo=1, frame_start=1, line_start=1.
- Horizontal timing: over one line, activevideo=1 for x 0..639 (640 clocks). hsync=0 exactly for x 664..703. x wraps 831→0 with line_start=1 and y incremented by 1.
- Vertical timing: over one frame, vsync=0 exactly for y 489..491 (3×832 = 2496 clocks). activevideo=0 for y 480..519. Frame length is 832×520 = 432640 clocks between frame_start pulses.
- Frame wrap: at (831,519) the next edge shows (0,0) with frame_start=1. No activevideo glitch occurs, and the second frame is identical to the first.
- Delay alignment, SYNC_DELAY=2: hsync_d falls 2 edges after hsync, at the edge where hsync first showed x=666. With SYNC_DELAY=0, hsync_d tracks hsync every cycle.
- Reset mid-operation: assert reset_n=0 for one edge at (700,490), while hsync and vsync are asserted. The next outputs are (0,0), activevideo=0 and hsync_d=vsync_d=1 immediately. The raster then restarts cleanly.
